gobou_activ: RTL and testbench

Multi-lane, mode-selectable activation stage for the gobou fully-connected datapath. It sits between the accumulator/bias stage and the output buffer. Each beat carries LANES signed pixels and is processed by a 2-stage valid/ready pipeline applying bypass, ReLU, leaky ReLU or clipped ReLU. It is the parametrised successor of the single-lane, single-mode ReLU stage and adds backpressure, a frame-end marker and an optional clip statistic.

---
 rtl/gobou_pkg.sv | 17 +
 rtl/gobou_activ_lane.sv | 55 +++++
 rtl/gobou_activ.sv | 149 ++++++++++++++
 tb/tb_gobou_activ.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gobou_pkg.sv
// Shared definitions for the gobou fully-connected datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gobou_pkg;

  // Default signed pixel width used across the datapath.
  localparam int GOBOU_DWIDTH = 16;

  // Activation function selector carried with every beat.
  typedef enum logic [1:0] {
    ACT_BYPASS = 2'd0,
    ACT_RELU   = 2'd1,
    ACT_LEAKY  = 2'd2,
    ACT_CLIP   = 2'd3
  } act_mode_e;

endpackage

// File: rtl/gobou_activ_lane.sv
// Per-lane activation function: bypass, ReLU, leaky ReLU or clipped ReLU.
// Latency: combinational.
// Backpressure: none, pure function of its inputs; macro GOBOU_ACTIV_CLIP_EN enables clipping.
module gobou_activ_lane
  import gobou_pkg::*;
#(
  parameter int DWIDTH     = GOBOU_DWIDTH,
  parameter int LEAK_SHIFT = 3
) (
  input  logic signed [DWIDTH-1:0] x,
  input  act_mode_e                mode,
  input  logic signed [DWIDTH-1:0] clip_max,
  output logic signed [DWIDTH-1:0] y,
  output logic                     clipped
);

  logic pos;
  assign pos = (x > 0);

`ifdef GOBOU_ACTIV_CLIP_EN
  // A non-positive ceiling collapses to zero so the output stays in [0, ceiling].
  logic signed [DWIDTH-1:0] ceiling;
  assign ceiling = (clip_max > 0) ? clip_max : '0;
`else
  logic unused_clip_max;
  assign unused_clip_max = ^clip_max;
`endif

  // Select the activation; every result fits in DWIDTH without widening.
  always_comb begin
    y       = x;
    clipped = 1'b0;
    case (mode)
      ACT_BYPASS: y = x;
      ACT_RELU:   y = pos ? x : '0;
      ACT_LEAKY:  y = pos ? x : (x >>> LEAK_SHIFT);
      ACT_CLIP: begin
`ifdef GOBOU_ACTIV_CLIP_EN
        if (!pos) begin
          y = '0;
        end else if (x > ceiling) begin
          y       = ceiling;
          clipped = 1'b1;
        end else begin
          y = x;
        end
`else
        y = pos ? x : '0;
`endif
      end
      default: y = x;
    endcase
  end

endmodule

// File: rtl/gobou_activ.sv
// Multi-lane activation stage between the accumulator/bias stage and the output buffer.
// Latency: 2 cycles (S1 input register, S2 output register); 1 beat/cycle sustained.
// Backpressure: holds up to 2 beats; in_ready = !s1_valid || !s2_valid || out_ready. Macro GOBOU_ACTIV_CLIP_EN adds mode 3 and clip_cnt.
module gobou_activ
  import gobou_pkg::*;
#(
  parameter int DWIDTH     = GOBOU_DWIDTH,
  parameter int LANES      = 4,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [1:0]                in_mode,
  input  logic [LANES*DWIDTH-1:0]   in_data,
  input  logic [DWIDTH-1:0]         clip_max,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_last,
  output logic [LANES*DWIDTH-1:0]   out_data,
  output logic [CNT_WIDTH-1:0]      clip_cnt,
  input  logic                      clip_clr
);

  localparam int BW = LANES * DWIDTH;

  logic            s1_valid;
  logic [BW-1:0]   s1_data;
  act_mode_e       s1_mode;
  logic            s1_last;
  logic [DWIDTH-1:0] s1_clip_max;

  logic            s2_valid;
  logic [BW-1:0]   s2_data;
  logic            s2_last;

  logic            s1_adv;
  logic            s2_adv;
  logic            in_fire;
  logic [BW-1:0]   act_data;
  logic [LANES-1:0] lane_clip;

  // S2 frees up when empty or draining; S1 moves on whenever S2 can take it.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s1_valid && s2_adv;
  assign in_ready = !s1_valid || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // S1: capture the beat together with its mode and last marker.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_mode  <= ACT_BYPASS;
      s1_last  <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= in_data;
      s1_mode  <= act_mode_e'(in_mode);
      s1_last  <= in_last;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

`ifdef GOBOU_ACTIV_CLIP_EN
  // Clip ceiling travels with its beat so mid-stream changes only affect later beats.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      s1_clip_max <= '0;
    end else if (in_fire) begin
      s1_clip_max <= clip_max;
    end
  end
`else
  assign s1_clip_max = '0;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    gobou_activ_lane #(
      .DWIDTH     (DWIDTH),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .x        (s1_data[i*DWIDTH +: DWIDTH]),
      .mode     (s1_mode),
      .clip_max (s1_clip_max),
      .y        (act_data[i*DWIDTH +: DWIDTH]),
      .clipped  (lane_clip[i])
    );
  end

  // S2: register activated lanes; contents hold while stalled downstream.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_last  <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= 1'b1;
      s2_data  <= act_data;
      s2_last  <= s1_last;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_last  = s2_last;

`ifdef GOBOU_ACTIV_CLIP_EN
  localparam int NW = $clog2(LANES + 1);

  logic [NW-1:0]        n_clip;
  logic [CNT_WIDTH:0]   cnt_sum;
  logic [CNT_WIDTH-1:0] clip_cnt_q;

  // Count clipped lanes of the beat currently in S1.
  always_comb begin
    n_clip = '0;
    for (int i = 0; i < LANES; i++) begin
      n_clip = n_clip + NW'(lane_clip[i]);
    end
  end

  assign cnt_sum = {1'b0, clip_cnt_q} + (CNT_WIDTH+1)'(n_clip);

  // Saturating clip statistic; a clear in the same cycle beats the increment.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      clip_cnt_q <= '0;
    end else if (clip_clr) begin
      clip_cnt_q <= '0;
    end else if (s1_adv) begin
      clip_cnt_q <= cnt_sum[CNT_WIDTH] ? '1 : cnt_sum[CNT_WIDTH-1:0];
    end
  end

  assign clip_cnt = clip_cnt_q;
`else
  logic unused_clip_in;
  assign unused_clip_in = ^{clip_max, clip_clr, lane_clip};
  assign clip_cnt = '0;
`endif

endmodule

// File: tb/tb_gobou_activ.sv
// Randomized plus directed bench for gobou_activ with a queue-based scoreboard.
// Latency: checks 2-edge latency from beat presentation to out_valid.
// Backpressure: random and directed out_ready stalls; in_ready checked every cycle.
module tb_gobou_activ;
  import gobou_pkg::*;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int LS = 3;
  localparam int CW = 16;
`ifdef GOBOU_ACTIV_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            xrst;
  logic            in_valid, in_ready, in_last;
  logic [1:0]      in_mode;
  logic [LN*DW-1:0] in_data;
  logic [DW-1:0]   clip_max;
  logic            out_valid, out_ready, out_last;
  logic [LN*DW-1:0] out_data;
  logic [CW-1:0]   clip_cnt;
  logic            clip_clr;

  gobou_activ #(.DWIDTH(DW), .LANES(LN), .LEAK_SHIFT(LS), .CNT_WIDTH(CW)) dut (
    .clk(clk), .xrst(xrst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mode(in_mode), .in_data(in_data), .clip_max(clip_max), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_data(out_data), .clip_cnt(clip_cnt),
    .clip_clr(clip_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LN*DW-1:0] data;
    logic             last;
  } exp_t;

  exp_t    sb[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      occ = 0;
  longint  clip_model = 0;
  int      policy = 0;  // 0: ready high, 1: random ready, 2: ready held low

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference activation from the plain arithmetic definition.
  function automatic int lane_ref(int x, int mode, int cm, output int clipped);
    int c;
    clipped = 0;
    c = (cm > 0) ? cm : 0;
    case (mode)
      0: return x;
      1: return (x > 0) ? x : 0;
      2: begin
        if (x > 0) return x;
        if (x % (1 << LS) == 0) return x / (1 << LS);
        return x / (1 << LS) - 1;
      end
      default: begin
        if (!CLIP_ON) return (x > 0) ? x : 0;
        if (x > c) clipped = 1;
        if (x <= 0) return 0;
        return (x > c) ? c : x;
      end
    endcase
  endfunction

  function automatic logic [LN*DW-1:0] pack(int a[LN]);
    logic [LN*DW-1:0] v;
    for (int i = 0; i < LN; i++) v[i*DW +: DW] = DW'(a[i]);
    return v;
  endfunction

  function automatic int rand_pix();
    int e[5] = '{-32768, -1, 0, 1, 32767};
    if ($urandom_range(0, 3) == 0) return e[$urandom_range(0, 4)];
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // One clock of stimulus: drive at negedge, record handshakes just after.
  task automatic step(input logic v, input int x[LN], input int mode, input int cm,
                      input logic last, output logic acc);
    exp_t e;
    int   nc, c;
    int   y[LN];
    @(negedge clk);
    case (policy)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 9) < 7);
      default: out_ready = 1'b0;
    endcase
    in_valid = v;
    in_mode  = mode[1:0];
    in_data  = pack(x);
    clip_max = DW'(cm);
    in_last  = last;
    #1;
    check("in_ready", {63'd0, in_ready}, {63'd0, !(occ == 2 && !out_ready)});
    acc = v && in_ready;
    if (acc) begin
      nc = 0;
      for (int i = 0; i < LN; i++) begin
        y[i] = lane_ref(x[i], mode, cm, c);
        nc += c;
      end
      e.data = pack(y);
      e.last = last;
      sb.push_back(e);
      occ++;
      clip_model = clip_model + nc;
      if (clip_model > (1 << CW) - 1) clip_model = (1 << CW) - 1;
    end
    if (out_valid && out_ready) occ--;
  endtask

  task automatic idle();
    int   z[LN] = '{0, 0, 0, 0};
    logic acc;
    step(1'b0, z, 0, 0, 1'b0, acc);
  endtask

  task automatic send(input int x[LN], input int mode, input int cm, input logic last);
    logic acc;
    bit   done = 1'b0;
    for (int t = 0; t < 64 && !done; t++) begin
      step(1'b1, x, mode, cm, last, acc);
      done = acc;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no in_ready expected accept within 64 cycles");
    end
  endtask

  task automatic send_and_expect(string name, input int x[LN], input int mode, input int cm,
                                 input int ex[LN]);
    policy = 0;
    send(x, mode, cm, 1'b1);
    idle();
    check({name, "_early_vld"}, {63'd0, out_valid}, 64'd0);
    idle();
    check({name, "_vld"}, {63'd0, out_valid}, 64'd1);
    check({name, "_dat"}, out_data, pack(ex));
    check({name, "_last"}, {63'd0, out_last}, 64'd1);
  endtask

  task automatic drain();
    policy = 0;
    for (int t = 0; t < 30 && (sb.size() != 0 || out_valid); t++) idle();
    idle();
    check("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Monitor: pops the scoreboard on each output handshake and checks stall stability.
  logic             prev_stall = 1'b0;
  logic [LN*DW-1:0] prev_dat;
  logic             prev_last;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!xrst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_vld", {63'd0, out_valid}, 64'd1);
          check("stall_dat", out_data, prev_dat);
          check("stall_last", {63'd0, out_last}, {63'd0, prev_last});
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL extra_beat: got %h expected none", out_data);
          end else begin
            e = sb.pop_front();
            check("sb_dat", out_data, e.data);
            check("sb_last", {63'd0, out_last}, {63'd0, e.last});
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_dat   = out_data;
        prev_last  = out_last;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bx[6][LN];
    int   bm[6];
    int   idx;
    logic acc;
    bit   saw_low;
    int   x[LN];
    int   m7[LN] = '{-7, -7, -7, -7};
    int   z7[LN] = '{0, 0, 0, 0};

    xrst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_mode = 2'd0; in_data = '0;
    clip_max = '0; out_ready = 1'b0; clip_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_clip_cnt", 64'(clip_cnt), 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    xrst = 1'b1;

    send_and_expect("relu", '{5, -3, 0, 32767}, 1, 0, '{5, 0, 0, 32767});
    send_and_expect("leaky", '{-16, -1, -32768, 7}, 2, 0, '{-2, -1, -4096, 7});

    // Clip statistic: clear, one clipping beat, clear again.
    clip_clr = 1'b1; idle(); clip_clr = 1'b0; clip_model = 0;
    idle();
    check("clip_cnt_clr0", 64'(clip_cnt), 64'd0);
    send_and_expect("clip", '{150, -5, 100, 101}, 3, 100,
                    CLIP_ON ? '{100, 0, 100, 100} : '{150, 0, 100, 101});
    check("clip_cnt_inc", 64'(clip_cnt), 64'(clip_model));
    clip_clr = 1'b1; idle(); clip_clr = 1'b0; clip_model = 0;
    idle();
    check("clip_cnt_clr1", 64'(clip_cnt), 64'd0);

    // Per-beat mode switch, back to back.
    for (int i = 0; i < 6; i++) send(m7, i % 2, 0, i == 5);
    drain();

    // Backpressure: 6 beats with ready low for 5 cycles mid-stream.
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < LN; i++) bx[b][i] = rand_pix();
      bm[b] = $urandom_range(0, 3);
    end
    idx = 0;
    saw_low = 1'b0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      policy = (c >= 2 && c < 7) ? 2 : 0;
      step(1'b1, bx[idx], bm[idx], 200, idx == 5, acc);
      if (!in_ready) saw_low = 1'b1;
      if (acc) idx++;
    end
    check("bp_all_sent", 64'(idx), 64'd6);
    check("bp_in_ready_drop", {63'd0, saw_low}, 64'd1);
    drain();

    // Randomized traffic with random backpressure.
    policy = 1;
    for (int b = 0; b < 300; b++) begin
      for (int i = 0; i < LN; i++) x[i] = rand_pix();
      if ($urandom_range(0, 9) < 3) begin
        idle();
      end
      send(x, $urandom_range(0, 3),
           ($urandom_range(0, 3) == 0) ? -int'($urandom_range(0, 100)) : int'($urandom_range(0, 32767)),
           $urandom_range(0, 7) == 0);
    end
    drain();
    check("rand_clip_cnt", 64'(clip_cnt), 64'(clip_model));

    // Reset with two beats in flight.
    policy = 2;
    send('{1, 2, 3, 4}, 0, 0, 1'b0);
    send('{5, 6, 7, 8}, 0, 0, 1'b1);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_full", 64'(occ), 64'd2);
    xrst = 1'b0;
    #1;
    check("mid_rst_vld", {63'd0, out_valid}, 64'd0);
    check("mid_rst_dat", out_data, 64'd0);
    check("mid_rst_last", {63'd0, out_last}, 64'd0);
    check("mid_rst_clip", 64'(clip_cnt), 64'd0);
    sb.delete();
    occ = 0;
    clip_model = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    xrst = 1'b1;
    send_and_expect("post_rst", '{-9, 9, -1, 1}, 1, 0, '{0, 9, 0, 1});
    drain();
    send(z7, 0, 0, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
